dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DSIZE, default 32: data width of all data buses.
REQ-002 Parameter AWIDTH, default 32: address width of all address buses.
REQ-003 Parameter MAX_HOLD, default 4: maximum consecutive locked grants to port B while port A waits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 a_req / a_we  input  1 / 1  core port: access request; write (1) or read (0).
REQ-007 a_addr / a_wdata  input  AWIDTH / DSIZE  core port address and write data.
REQ-008 a_gnt / a_rvalid  output  1 / 1  core access granted this cycle; core read data valid.
REQ-009 a_rdata  output  DSIZE  core read data.
REQ-010 core_stall  output  1  core must hold its PC/pipeline this cycle.
REQ-011 b_req / b_we / b_lock  input  1 / 1 / 1  loader/debug port: request, write, request back-to-back ownership.
REQ-012 b_addr / b_wdata  input  AWIDTH / DSIZE  loader port address and write data.
REQ-013 b_gnt / b_rvalid  output  1 / 1  loader access granted; loader read data valid.
REQ-014 b_rdata  output  DSIZE  loader read data.
REQ-015 mem_read_en / mem_write_en  output  1 / 1  data-memory strobes.
REQ-016 mem_addr / mem_wdata  output  AWIDTH / DSIZE  data-memory address and write data.
REQ-017 mem_rdata  input  DSIZE  data-memory read data, valid one cycle after mem_read_en.

Function
REQ-018 At most one of a_gnt, b_gnt SHALL be high in any cycle; gnt is combinational from req and registered state.
REQ-019 A granted access SHALL drive mem_* in the same cycle: mem_read_en = ~we, mem_write_en = we, addr/wdata from the granted port.
REQ-020 With no grant, mem_read_en, mem_write_en SHALL be 0 and mem_addr, mem_wdata SHALL be 0.
REQ-021 Only one port requesting: that port SHALL be granted.
REQ-022 Both requesting, no active lock: grant SHALL go to the port not granted most recently (round-robin pointer, reset favours A).
REQ-023 Lock: if B was granted last cycle with b_lock=1 and b_req=1 now, B SHALL be granted again, unless hold_cnt = MAX_HOLD and a_req=1, then A SHALL be granted.
REQ-024 hold_cnt SHALL increment on each locked consecutive B grant while a_req=1, saturate at MAX_HOLD, clear on any A grant, any cycle without a B grant, or b_lock=0.
REQ-025 Requesters SHALL hold req, we, addr, wdata stable until gnt; the arbiter does not latch ungranted requests.
REQ-026 x_rvalid SHALL be 1 exactly one cycle after a granted read on port x, with x_rdata = mem_rdata in that cycle; never for writes.
REQ-027 x_rdata SHALL be 0 whenever x_rvalid=0.
REQ-028 core_stall SHALL equal a_req & ~a_gnt.
REQ-029 Back-to-back grants SHALL be sustained: one access per cycle, no bubble cycles, reads pipelined.

Reset
REQ-030 During rst=1: a_gnt, b_gnt, mem strobes, rvalids, core_stall SHALL be 0 regardless of inputs; pointer SHALL favour A; hold_cnt SHALL be 0.
REQ-031 rst asserted with a read outstanding: the corresponding rvalid SHALL NOT be asserted after reset.
REQ-032 First cycle after rst deasserts SHALL arbitrate normally.

Verification
REQ-033 A read only, a_addr=0x10, memory holds 0xDEADBEEF: a_gnt=1, mem_read_en=1 same cycle; next cycle a_rvalid=1, a_rdata=0xDEADBEEF.
REQ-034 A and B request every cycle, no lock, for 6 cycles: grants A,B,A,B,A,B; core_stall=1 on B-granted cycles.
REQ-035 B write with b_lock=1 continuous, A requesting continuously, MAX_HOLD=4: B granted 4 consecutive cycles after its first grant, then A granted once.
REQ-036 B write addr 0x20 data 0x12345678, then A read 0x20: a_rdata=0x12345678 one cycle after a_gnt.
REQ-037 rst pulsed the cycle after a granted B read: b_rvalid stays 0; all outputs 0 during reset.
REQ-038 No requests: mem strobes 0, mem_addr=0, both gnt 0, core_stall=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core port (A) and a loader/debug port (B).
// One access per cycle is forwarded to a single-ported data memory with a
// one-cycle read latency. Contention is resolved round-robin. Port B may
// request back-to-back ownership with b_lock, but only for a bounded number
// of cycles while the core is waiting.
module dmem_arbiter #(
  parameter int DSIZE    = 32,
  parameter int AWIDTH   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  // core port
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DSIZE-1:0]  a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DSIZE-1:0]  a_rdata,
  output logic              core_stall,
  // loader / debug port
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DSIZE-1:0]  b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DSIZE-1:0]  b_rdata,
  // data memory
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DSIZE-1:0]  mem_wdata,
  input  logic [DSIZE-1:0]  mem_rdata
);

  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  // Which port owns the read currently in flight in the memory.
  typedef enum logic [1:0] {
    RD_NONE,
    RD_A,
    RD_B
  } rd_owner_t;

  rd_owner_t       rd_owner;
  logic            favour_b;       // round-robin pointer: 1 = B wins next tie
  logic            b_locked_last;  // B granted last cycle with b_lock set
  logic [HW-1:0]   hold_cnt;       // locked B grants taken while A waited

  logic            gnt_a;
  logic            gnt_b;
  logic            lock_active;
  logic            hold_expired;

  // Grant decision: lock first, then round-robin on contention, else lone requester.
  always_comb begin
    gnt_a        = 1'b0;
    gnt_b        = 1'b0;
    lock_active  = b_locked_last & b_req;
    hold_expired = (hold_cnt == HOLD_MAX) & a_req;
    if (!rst) begin
      if (lock_active) begin
        if (hold_expired) begin
          gnt_a = 1'b1;
        end else begin
          gnt_b = 1'b1;
        end
      end else if (a_req && b_req) begin
        gnt_b = favour_b;
        gnt_a = ~favour_b;
      end else begin
        gnt_a = a_req;
        gnt_b = b_req;
      end
    end
  end

  // Memory request mux: the granted port drives the memory, idle bus is all zero.
  always_comb begin
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    if (gnt_a) begin
      mem_read_en  = ~a_we;
      mem_write_en = a_we;
      mem_addr     = a_addr;
      mem_wdata    = a_wdata;
    end else if (gnt_b) begin
      mem_read_en  = ~b_we;
      mem_write_en = b_we;
      mem_addr     = b_addr;
      mem_wdata    = b_wdata;
    end
  end

  // Arbitration state: round-robin pointer, lock tracking, hold counter, read owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      favour_b      <= 1'b0;
      b_locked_last <= 1'b0;
      hold_cnt      <= '0;
      rd_owner      <= RD_NONE;
    end else begin
      if (gnt_a) begin
        favour_b <= 1'b1;
      end else if (gnt_b) begin
        favour_b <= 1'b0;
      end

      b_locked_last <= gnt_b & b_lock;

      // Only locked consecutive B grants count; anything else restarts the budget.
      if (gnt_b && b_lock && lock_active) begin
        if (a_req && (hold_cnt != HOLD_MAX)) begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end else begin
        hold_cnt <= '0;
      end

      if (gnt_a && !a_we) begin
        rd_owner <= RD_A;
      end else if (gnt_b && !b_we) begin
        rd_owner <= RD_B;
      end else begin
        rd_owner <= RD_NONE;
      end
    end
  end

  // Outputs; the rvalid terms are masked by rst so a read in flight at reset never returns.
  always_comb begin
    a_gnt      = gnt_a;
    b_gnt      = gnt_b;
    core_stall = a_req & ~gnt_a & ~rst;
    a_rvalid   = (rd_owner == RD_A) & ~rst;
    b_rvalid   = (rd_owner == RD_B) & ~rst;
    a_rdata    = a_rvalid ? mem_rdata : '0;
    b_rdata    = b_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for data return, round-robin, lock hold and reset.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [31:0] a_addr = '0, a_wdata = '0;
  logic        a_gnt, a_rvalid, core_stall;
  logic [31:0] a_rdata;
  logic        b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
  logic [31:0] b_addr = '0, b_wdata = '0;
  logic        b_gnt, b_rvalid;
  logic [31:0] b_rdata;
  logic        mem_read_en, mem_write_en;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DSIZE(32), .AWIDTH(32), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .core_stall(core_stall),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural data memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read_en) mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit rst, ar, aw, br, bw, bl;
    bit ag, bg, st, rd, wr, arv, brv;
  } vec_t;

  vec_t vec [17];

  task automatic idle();
    a_req = 1'b0; a_we = 1'b0; b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_addr, exp_wdata;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 + i;

    //             rst ar aw br bw bl | ag bg st rd wr arv brv
    vec[0]  = '{1, 1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    vec[2]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0};
    vec[3]  = '{0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0};
    vec[4]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0};
    vec[5]  = '{0, 1, 0, 1, 0, 0,  0, 1, 1, 1, 0, 0, 0};
    vec[6]  = '{0, 1, 0, 1, 0, 0,  1, 0, 0, 1, 0, 0, 1};
    vec[7]  = '{0, 1, 1, 1, 0, 0,  0, 1, 1, 1, 0, 1, 0};
    vec[8]  = '{0, 1, 1, 1, 0, 0,  1, 0, 0, 0, 1, 0, 1};
    vec[9]  = '{0, 0, 0, 1, 1, 0,  0, 1, 0, 0, 1, 0, 0};
    vec[10] = '{0, 1, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0};
    vec[11] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0};
    vec[12] = '{0, 0, 0, 1, 0, 1,  0, 1, 0, 1, 0, 0, 0};
    vec[13] = '{0, 1, 0, 1, 0, 1,  0, 1, 1, 1, 0, 0, 1};
    vec[14] = '{0, 1, 0, 1, 0, 0,  0, 1, 1, 1, 0, 0, 1};
    vec[15] = '{0, 1, 0, 1, 0, 0,  1, 0, 0, 1, 0, 0, 1};
    vec[16] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0};

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = vec[i].rst;
      a_req = vec[i].ar; a_we = vec[i].aw;
      b_req = vec[i].br; b_we = vec[i].bw; b_lock = vec[i].bl;
      a_addr = 32'h100 + 32'(i * 4); a_wdata = 32'h1000_0000 + 32'(i);
      b_addr = 32'h200 + 32'(i * 4); b_wdata = 32'h2000_0000 + 32'(i);
      #1;
      exp_addr  = vec[i].ag ? a_addr  : vec[i].bg ? b_addr  : 32'h0;
      exp_wdata = vec[i].ag ? a_wdata : vec[i].bg ? b_wdata : 32'h0;
      chk($sformatf("v%0d a_gnt", i),       32'(a_gnt),        32'(vec[i].ag));
      chk($sformatf("v%0d b_gnt", i),       32'(b_gnt),        32'(vec[i].bg));
      chk($sformatf("v%0d core_stall", i),  32'(core_stall),   32'(vec[i].st));
      chk($sformatf("v%0d mem_read_en", i), 32'(mem_read_en),  32'(vec[i].rd));
      chk($sformatf("v%0d mem_write_en", i),32'(mem_write_en), 32'(vec[i].wr));
      chk($sformatf("v%0d a_rvalid", i),    32'(a_rvalid),     32'(vec[i].arv));
      chk($sformatf("v%0d b_rvalid", i),    32'(b_rvalid),     32'(vec[i].brv));
      chk($sformatf("v%0d mem_addr", i),    mem_addr,          exp_addr);
      chk($sformatf("v%0d mem_wdata", i),   mem_wdata,         exp_wdata);
      if (!vec[i].arv) chk($sformatf("v%0d a_rdata idle", i), a_rdata, 32'h0);
      if (!vec[i].brv) chk($sformatf("v%0d b_rdata idle", i), b_rdata, 32'h0);
    end
    @(negedge clk);
    idle();

    // ---------------- read data, write-then-read ----------------
    mem[8'h10] = 32'hDEADBEEF;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h10;
    #1;
    chk("rd10 a_gnt", 32'(a_gnt), 32'd1);
    chk("rd10 mem_read_en", 32'(mem_read_en), 32'd1);
    chk("rd10 mem_addr", mem_addr, 32'h10);
    @(negedge clk);
    idle();
    #1;
    chk("rd10 a_rvalid", 32'(a_rvalid), 32'd1);
    chk("rd10 a_rdata", a_rdata, 32'hDEADBEEF);
    chk("rd10 b_rvalid", 32'(b_rvalid), 32'd0);

    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 32'h20; b_wdata = 32'h12345678;
    #1;
    chk("wr20 b_gnt", 32'(b_gnt), 32'd1);
    chk("wr20 mem_write_en", 32'(mem_write_en), 32'd1);
    chk("wr20 mem_wdata", mem_wdata, 32'h12345678);
    @(negedge clk);
    idle();
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h20;
    #1;
    chk("rd20 a_gnt", 32'(a_gnt), 32'd1);
    chk("wr20 b_rvalid (write)", 32'(b_rvalid), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("rd20 a_rvalid", 32'(a_rvalid), 32'd1);
    chk("rd20 a_rdata", a_rdata, 32'h12345678);

    // ---------------- round-robin, both requesting 6 cycles ----------------
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h40;
      b_req = 1'b1; b_we = 1'b0; b_lock = 1'b0; b_addr = 32'h44;
      #1;
      chk($sformatf("rr%0d a_gnt", i), 32'(a_gnt), 32'((i % 2) == 0));
      chk($sformatf("rr%0d b_gnt", i), 32'(b_gnt), 32'((i % 2) == 1));
      chk($sformatf("rr%0d core_stall", i), 32'(core_stall), 32'((i % 2) == 1));
      if (i > 0) begin
        chk($sformatf("rr%0d a_rvalid", i), 32'(a_rvalid), 32'((i % 2) == 1));
        chk($sformatf("rr%0d b_rvalid", i), 32'(b_rvalid), 32'((i % 2) == 0));
      end
    end
    @(negedge clk);
    idle();

    // ---------------- lock hold limit: A,B,B,B,B,B,A,B ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 32'h50;
      b_req = 1'b1; b_we = 1'b1; b_lock = 1'b1; b_addr = 32'h60; b_wdata = 32'(i);
      #1;
      chk($sformatf("lock%0d a_gnt", i), 32'(a_gnt), 32'(i == 0 || i == 6));
      chk($sformatf("lock%0d b_gnt", i), 32'(b_gnt), 32'(!(i == 0 || i == 6)));
    end
    @(negedge clk);
    idle();

    // ---------------- reset with a B read in flight ----------------
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 32'h20;
    #1;
    chk("rstrd b_gnt", 32'(b_gnt), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    a_req = 1'b1; b_req = 1'b1; b_lock = 1'b1;
    #1;
    chk("rstrd b_rvalid in rst", 32'(b_rvalid), 32'd0);
    chk("rstrd b_rdata in rst", b_rdata, 32'h0);
    chk("rstrd a_gnt in rst", 32'(a_gnt), 32'd0);
    chk("rstrd b_gnt in rst", 32'(b_gnt), 32'd0);
    chk("rstrd mem_read_en in rst", 32'(mem_read_en), 32'd0);
    chk("rstrd core_stall in rst", 32'(core_stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rstrd b_rvalid after", 32'(b_rvalid), 32'd0);
    chk("rstrd mem_addr idle", mem_addr, 32'h0);
    chk("rstrd core_stall idle", 32'(core_stall), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
